// File: rtl/adc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : adc_ctrl
//  Purpose  : Initiator side of a 12-bit ADC start/EOC/OE handshake. A free
//             running tick launches a conversion, the controller follows EOC
//             fall and rise, pulses OE to read the result and hands the
//             captured sample on with a one-cycle valid strobe. Missed ticks
//             and EOC timeouts are flagged in sticky bits.
//  Ports    : clk, rst (async, active-high)
//             enable        - periodic sampling runs while high
//             adc_eoc       - ADC end-of-conversion (idle high)
//             adc_data      - ADC parallel data, valid while adc_oe high
//             adc_start     - conversion start pulse
//             adc_oe        - ADC output enable
//             sample        - last captured conversion
//             sample_valid  - one-cycle strobe when sample updates
//             busy          - FSM not idle
//             overrun       - sticky, tick arrived while busy
//             timeout_err   - sticky, EOC handshake timed out
//             err_clr       - synchronous clear of the sticky flags
//  Revision : 1.0 - initial release
// ============================================================================
module adc_ctrl #(
    parameter int SAMPLE_DIV  = 1000,
    parameter int START_WIDTH = 2,
    parameter int OE_WIDTH    = 2,
    parameter int EOC_TIMEOUT = 2000,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_start,
    output logic              adc_oe,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int PH_MAX = (START_WIDTH > OE_WIDTH) ? START_WIDTH : OE_WIDTH;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(EOC_TIMEOUT);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]   START_LAST = PH_W'(START_WIDTH - 1);
    localparam logic [PH_W-1:0]   OE_LAST    = PH_W'(OE_WIDTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(EOC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_READ      = 3'd4,
        ST_ABORT     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [PH_W-1:0]     r_ph;
    logic [TO_W-1:0]     r_to;
    logic                r_eoc_q1;
    logic                r_eoc_s;
    logic                w_tick;
    logic                w_timeout;

    assign w_tick    = enable && (r_tick_cnt == TICK_LAST);
    assign w_timeout = (r_to == TO_LAST);
    assign busy      = (r_state != ST_IDLE);

    // EOC synchroniser, preset to the ADC idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eoc_q1 <= 1'b1;
            r_eoc_s  <= 1'b1;
        end else begin
            r_eoc_q1 <= adc_eoc;
            r_eoc_s  <= r_eoc_q1;
        end
    end

    // Sample-period counter, parked at zero while sampling is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (!enable || (r_tick_cnt == TICK_LAST)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:      if (w_tick) w_state_nx = ST_START;
            ST_START:     if (r_ph == START_LAST) w_state_nx = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                if (w_timeout)     w_state_nx = ST_ABORT;
                else if (!r_eoc_s) w_state_nx = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (w_timeout)    w_state_nx = ST_ABORT;
                else if (r_eoc_s) w_state_nx = ST_READ;
            end
            ST_READ:      if (r_ph == OE_LAST) w_state_nx = ST_IDLE;
            ST_ABORT:     w_state_nx = ST_IDLE;
            default:      w_state_nx = ST_IDLE;
        endcase
    end

    // Phase counter for the fixed-length START and READ states; the timeout
    // counter spans both wait states, so it only clears while in START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph <= '0;
            r_to <= '0;
        end else begin
            if (w_state_nx != r_state) begin
                r_ph <= '0;
            end else if ((r_state == ST_START) || (r_state == ST_READ)) begin
                r_ph <= r_ph + 1'b1;
            end

            if (r_state == ST_START) begin
                r_to <= '0;
            end else if ((r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH)) begin
                r_to <= r_to + 1'b1;
            end
        end
    end

    // Strobes are registered decodes of the state, so they trail the state
    // by one cycle. The last OE cycle is therefore the one in which adc_oe
    // is still high but the state has already left READ; the data is taken
    // at the end of that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_start    <= 1'b0;
            adc_oe       <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            adc_start    <= (r_state == ST_START);
            adc_oe       <= (r_state == ST_READ);
            sample_valid <= 1'b0;
            if (adc_oe && (r_state != ST_READ)) begin
                sample       <= adc_data;
                sample_valid <= 1'b1;
            end
        end
    end

    // Sticky flags: a set event wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (w_tick && (r_state != ST_IDLE)) overrun <= 1'b1;
            else if (err_clr)                   overrun <= 1'b0;

            if (r_state == ST_ABORT) timeout_err <= 1'b1;
            else if (err_clr)        timeout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
